// File: rtl/led_pattern_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: channel modes and per-channel FSM states.
package led_pat_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_LOOP    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/led_pattern_seq_if.sv
// Configuration write channel: valid/ready handshake plus the per-channel settings.
interface led_pattern_seq_if #(
  parameter int CH    = 4,
  parameter int PAT_W = 8,
  parameter int TW    = 32
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int LW  = $clog2(PAT_W) + 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  logic [1:0]       cfg_mode;
  logic [TW-1:0]    cfg_time_set;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_time_set, cfg_pattern, cfg_len,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_time_set, cfg_pattern, cfg_len,
    output cfg_ready
  );

endinterface

// File: rtl/led_pattern_seq_chan.sv
// One LED channel: step timer, bit index, IDLE/RUN FSM and registered led/done outputs.
//   state   | meaning
//   ST_IDLE | timer frozen; led dark, or last bit held after an ONESHOT_HOLD run
//   ST_RUN  | timer counting, index stepping through the pattern
module led_pat_chan
  import led_pat_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int TW    = 32,
  parameter int LW    = $clog2(PAT_W) + 1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       cfg_mode,
  input  logic [TW-1:0]    cfg_time_set,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  output logic             led,
  output logic             done
);
  localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  state_e           state_q;
  state_e           state_nxt;
  mode_e            mode_q;
  logic [TW-1:0]    period_q;
  logic [TW-1:0]    timer_q;
  logic [PAT_W-1:0] pattern_q;
  logic [LW-1:0]    len_q;
  logic [IW-1:0]    idx_q;
  logic             fin_q;
  logic             fin_nxt;
  logic             led_q;
  logic             led_nxt;
  logic             done_q;

  logic [TW-1:0]    period_in;
  logic [LW-1:0]    len_in;
  logic             step_end;
  logic             last_bit;
  logic [IW-1:0]    hold_idx;

  // Period and length are normalised once at write time so the run logic never sees 0.
  always_comb begin
    period_in = (cfg_time_set == '0) ? TW'(1) : cfg_time_set;
    len_in    = cfg_len;
    if (cfg_len == '0) begin
      len_in = LW'(1);
    end else if (cfg_len > LW'(PAT_W)) begin
      len_in = LW'(PAT_W);
    end
  end

  assign step_end = (state_q == ST_RUN) && (timer_q == period_q - TW'(1));
  assign last_bit = (LW'(idx_q) == len_q - LW'(1));
  assign hold_idx = IW'(len_q - LW'(1));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      period_q  <= '0;
      timer_q   <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      fin_q     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      fin_q   <= fin_nxt;
      if (wr_en) begin
        mode_q    <= mode_e'(cfg_mode);
        period_q  <= period_in;
        pattern_q <= cfg_pattern;
        len_q     <= len_in;
        timer_q   <= '0;
        idx_q     <= '0;
      end else if (state_q == ST_RUN) begin
        if (step_end) begin
          timer_q <= '0;
          idx_q   <= last_bit ? '0 : idx_q + IW'(1);
        end else begin
          timer_q <= timer_q + TW'(1);
        end
      end
    end
  end

  // A write on the terminal step overrides completion, so no done is raised.
  always_comb begin
    state_nxt = state_q;
    fin_nxt   = 1'b0;
    if (wr_en) begin
      state_nxt = (cfg_mode == MODE_OFF) ? ST_IDLE : ST_RUN;
    end else if (step_end && last_bit && (mode_q != MODE_LOOP)) begin
      state_nxt = ST_IDLE;
      fin_nxt   = 1'b1;
    end
  end

  always_comb begin
    led_nxt = 1'b0;
    if (state_q == ST_RUN) begin
      led_nxt = pattern_q[idx_q];
    end else if (mode_q == MODE_HOLD) begin
      led_nxt = pattern_q[hold_idx];
    end
  end

  // done is delayed one stage so it lines up with the edge where led goes dark.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      led_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      led_q  <= led_nxt;
      done_q <= fin_q;
    end
  end

  assign led  = led_q;
  assign done = done_q;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer top: decodes configuration writes onto CH independent channels.
module led_pattern_seq
  import led_pat_pkg::*;
#(
  parameter int CH    = 4,
  parameter int PAT_W = 8,
  parameter int TW    = 32
) (
  input  logic          sys_clk,
  input  logic          rst,
  led_pattern_seq_if.slave cfg,
  output logic [CH-1:0] led,
  output logic [CH-1:0] done
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic accept;

  assign cfg.cfg_ready = ~rst;
  assign accept        = cfg.cfg_valid & ~rst;

  // Indices at or above CH match no channel, so such writes are accepted and dropped.
  for (genvar c = 0; c < CH; c++) begin : g_chan
    logic wr_en;
    assign wr_en = accept && (cfg.cfg_ch == CHW'(c));

    led_pat_chan #(
      .PAT_W (PAT_W),
      .TW    (TW)
    ) u_chan (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .cfg_mode     (cfg.cfg_mode),
      .cfg_time_set (cfg.cfg_time_set),
      .cfg_pattern  (cfg.cfg_pattern),
      .cfg_len      (cfg.cfg_len),
      .led          (led[c]),
      .done         (done[c])
    );
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: vector table plus hand-written multi-cycle sequences.
module tb_led_pattern_seq;
  import led_pat_pkg::*;

  // Five channels so that out-of-range indices (5, 7) are encodable on the 3-bit channel field.
  localparam int CH    = 5;
  localparam int PAT_W = 8;
  localparam int TW    = 32;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic [CH-1:0] led;
  logic [CH-1:0] done;

  int n_cmp = 0;
  int n_err = 0;

  led_pattern_seq_if #(.CH(CH), .PAT_W(PAT_W), .TW(TW)) cfg_bus ();

  led_pattern_seq #(.CH(CH), .PAT_W(PAT_W), .TW(TW)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .cfg     (cfg_bus),
    .led     (led),
    .done    (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         ch;
    logic [1:0] mode;
    int         ts;
    logic [7:0] pat;
    logic [3:0] len;
    int         n;
    logic       exp_led;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write(input int ch, input logic [1:0] mode, input int ts,
                       input logic [7:0] pat, input logic [3:0] len);
    cfg_bus.cfg_valid    = 1'b1;
    cfg_bus.cfg_ch       = 3'(ch);
    cfg_bus.cfg_mode     = mode;
    cfg_bus.cfg_time_set = 32'(ts);
    cfg_bus.cfg_pattern  = pat;
    cfg_bus.cfg_len      = len;
    tick();
    cfg_bus.cfg_valid    = 1'b0;
  endtask

  function automatic void add(input int ch, input logic [1:0] mode, input int ts,
                              input logic [7:0] pat, input logic [3:0] len, input int n,
                              input logic l, input logic d);
    vec_t v;
    v.ch = ch; v.mode = mode; v.ts = ts; v.pat = pat; v.len = len;
    v.n = n; v.exp_led = l; v.exp_done = d;
    vecs.push_back(v);
  endfunction

  // LOOP reference: n cycles after the accepting edge, led shows bit ((n-1)/period) mod len.
  function automatic logic loop_led(input logic [7:0] pat, input int p, input int l, input int n);
    int idx;
    idx = ((n - 1) / p) % l;
    return pat[3'(idx)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad_a, bad_b;
    int   n0, n1;

    cfg_bus.cfg_valid    = 1'b0;
    cfg_bus.cfg_ch       = '0;
    cfg_bus.cfg_mode     = '0;
    cfg_bus.cfg_time_set = '0;
    cfg_bus.cfg_pattern  = '0;
    cfg_bus.cfg_len      = '0;

    // ch, mode, ts, pattern, len, cycles after accept, led, done
    add(0, MODE_LOOP,    2, 8'h59,        8,  1, 1'b1, 1'b0);
    add(0, MODE_LOOP,    2, 8'h59,        8,  2, 1'b1, 1'b0);
    add(0, MODE_LOOP,    2, 8'h59,        8,  3, 1'b0, 1'b0);
    add(0, MODE_LOOP,    2, 8'h59,        8,  9, 1'b1, 1'b0);
    add(0, MODE_LOOP,    2, 8'h59,        8, 15, 1'b0, 1'b0);
    add(0, MODE_LOOP,    2, 8'h59,        8, 17, 1'b1, 1'b0);
    add(1, MODE_ONESHOT, 3, 8'b0000_0101, 3,  1, 1'b1, 1'b0);
    add(1, MODE_ONESHOT, 3, 8'b0000_0101, 3,  4, 1'b0, 1'b0);
    add(1, MODE_ONESHOT, 3, 8'b0000_0101, 3,  7, 1'b1, 1'b0);
    add(1, MODE_ONESHOT, 3, 8'b0000_0101, 3,  9, 1'b1, 1'b0);
    add(1, MODE_ONESHOT, 3, 8'b0000_0101, 3, 10, 1'b0, 1'b1);
    add(1, MODE_ONESHOT, 3, 8'b0000_0101, 3, 11, 1'b0, 1'b0);
    add(2, MODE_HOLD,    0, 8'b0000_0010, 2,  1, 1'b0, 1'b0);
    add(2, MODE_HOLD,    0, 8'b0000_0010, 2,  2, 1'b1, 1'b0);
    add(2, MODE_HOLD,    0, 8'b0000_0010, 2,  3, 1'b1, 1'b1);
    add(2, MODE_HOLD,    0, 8'b0000_0010, 2,  4, 1'b1, 1'b0);
    add(2, MODE_HOLD,    0, 8'b0000_0010, 2, 20, 1'b1, 1'b0);
    add(3, MODE_LOOP,    1, 8'b0000_0001, 0,  2, 1'b1, 1'b0);
    add(3, MODE_ONESHOT, 0, 8'h80,       12,  8, 1'b1, 1'b0);
    add(3, MODE_ONESHOT, 0, 8'h80,       12,  9, 1'b0, 1'b1);
    add(4, MODE_ONESHOT, 0, 8'h01,        0,  1, 1'b1, 1'b0);
    add(4, MODE_ONESHOT, 0, 8'h01,        0,  2, 1'b0, 1'b1);
    add(0, MODE_OFF,     5, 8'hFF,        8,  1, 1'b0, 1'b0);
    add(0, MODE_OFF,     5, 8'hFF,        8,  6, 1'b0, 1'b0);

    // Reset state
    repeat (3) tick();
    check("reset led", led, 0);
    check("reset done", done, 0);
    check("reset cfg_ready", cfg_bus.cfg_ready, 0);
    rst = 1'b0;
    #1;
    check("run cfg_ready", cfg_bus.cfg_ready, 1);
    repeat (20) tick();
    check("dark after reset", led, 0);

    foreach (vecs[i]) begin
      write(vecs[i].ch, vecs[i].mode, vecs[i].ts, vecs[i].pat, vecs[i].len);
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d led", i), led[vecs[i].ch], vecs[i].exp_led);
      check($sformatf("vec%0d done", i), done[vecs[i].ch], vecs[i].exp_done);
    end

    // Two full LOOP passes, first and last cycle of every bit
    write(0, MODE_LOOP, 50, 8'h59, 8);
    bad_a = 1'b0;
    for (int n = 1; n <= 800; n++) begin
      tick();
      if (done[0]) bad_a = 1'b1;
      if (((n - 1) % 50 == 0) || (n % 50 == 0))
        check($sformatf("loop50 n%0d", n), led[0], loop_led(8'h59, 50, 8, n));
    end
    check("loop50 no done", bad_a, 0);

    // Write landing on the terminal step of a LOOP
    write(0, MODE_LOOP, 4, 8'h00, 8);
    repeat (3) tick();
    check("term pre led", led[0], 0);
    write(0, MODE_LOOP, 4, 8'hFF, 8);
    tick();
    check("term ff led", led[0], 1);
    check("term ff done", done[0], 0);
    write(0, MODE_LOOP, 4, 8'h00, 8);
    repeat (3) tick();
    write(0, MODE_LOOP, 4, 8'h01, 8);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check($sformatf("term idx0 n%0d", n), led[0], 1);
    end
    tick();
    check("term idx1", led[0], 0);

    // Write landing on a ONESHOT's final step suppresses that done
    write(1, MODE_ONESHOT, 2, 8'h00, 1);
    tick();
    write(1, MODE_ONESHOT, 2, 8'h01, 1);
    tick();
    check("os coincide done", done[1], 0);
    check("os coincide led", led[1], 1);
    tick();
    check("os second done0", done[1], 0);
    tick();
    check("os second done1", done[1], 1);
    check("os second led", led[1], 0);

    // One-cycle reset mid-run, landing on a pending done
    write(0, MODE_LOOP, 3, 8'h01, 8);
    write(2, MODE_LOOP, 1, 8'hFF, 8);
    write(1, MODE_HOLD, 0, 8'h01, 1);
    repeat (10) tick();
    check("pre-rst led2", led[2], 1);
    check("pre-rst led1", led[1], 1);
    write(4, MODE_ONESHOT, 0, 8'h01, 1);
    tick();
    rst = 1'b1;
    #1;
    check("rst cfg_ready", cfg_bus.cfg_ready, 0);
    tick();
    rst = 1'b0;
    check("rst led", led, 0);
    check("rst done", done, 0);
    bad_a = 1'b0;
    bad_b = 1'b0;
    repeat (30) begin
      tick();
      if (led != '0) bad_a = 1'b1;
      if (done != '0) bad_b = 1'b1;
    end
    check("post-rst dark", bad_a, 0);
    check("post-rst no done", bad_b, 0);

    // Out-of-range writes and a write to ch2 must not disturb ch0/ch1
    write(0, MODE_LOOP, 2, 8'h59, 8);
    write(1, MODE_LOOP, 3, 8'b0000_0011, 3);
    n0 = 1;
    n1 = 0;
    for (int i = 0; i < 110; i++) begin
      cfg_bus.cfg_valid    = (i == 10) || (i == 11) || (i == 40);
      cfg_bus.cfg_ch       = (i == 10) ? 3'd5 : ((i == 11) ? 3'd7 : 3'd2);
      cfg_bus.cfg_mode     = MODE_LOOP;
      cfg_bus.cfg_time_set = '0;
      cfg_bus.cfg_pattern  = 8'hFF;
      cfg_bus.cfg_len      = 4'd8;
      tick();
      cfg_bus.cfg_valid    = 1'b0;
      n0++;
      n1++;
      check($sformatf("indep led0 i%0d", i), led[0], loop_led(8'h59, 2, 8, n0));
      check($sformatf("indep led1 i%0d", i), led[1], loop_led(8'b0000_0011, 3, 3, n1));
      check($sformatf("indep led2 i%0d", i), led[2], (i >= 41) ? 1 : 0);
      check($sformatf("indep led3 i%0d", i), led[3], 0);
      check($sformatf("indep led4 i%0d", i), led[4], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
